// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants and types for the pipelined data memory.
// Default geometry matches the CPU bench build (32-bit words, 64 entries,
// four outstanding reads). Optional random request stall: DMEM_RAND_STALL_EN.
package dmem_pkg;

   localparam int DMEM_WIDTH  = 32;
   localparam int DMEM_ADDR_W = 6;
   localparam int DMEM_QDEPTH = 4;

   // Byte-enable width and outstanding-count width for the default geometry.
   localparam int DMEM_BE_W  = DMEM_WIDTH / 8;
   localparam int DMEM_CNT_W = $clog2(DMEM_QDEPTH) + 1;

   // Seed for the request back-pressure LFSR; must be non-zero.
   localparam logic [7:0] LFSR_SEED = 8'hA5;

   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_WIDTH-1:0]  wdata;
      logic [DMEM_BE_W-1:0]   be;
   } dmem_req_t;

   // Width needed to count 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/dmem_pipe_resp_fifo.sv
// resp_fifo: WIDTH x DEPTH circular FIFO holding read responses until the
// consumer takes them. Overflow is prevented upstream by the outstanding-read
// limit, so a push is never refused.
module resp_fifo
   import dmem_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head,
   output logic                    empty,
   output logic [cnt_w(DEPTH)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = cnt_w(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             pop_ok;

   // A pop on an empty FIFO is a no-op (rsp_valid was low).
   assign pop_ok = pop && !empty;
   assign empty  = (count == '0);
   assign head   = store[rptr];

   // Entry storage: written at the write pointer on every push.
   // NOTE: storage arrays carry no reset; validity is tracked by the pointers and count, and resetting RAM would stop it mapping to memory macros.
   always_ff @(posedge clk) begin
      if (push) store[wptr] <= push_data;
   end

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   // NOTE: sequential state is assigned with <= so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push)   wptr <= wptr + 1'b1;
         if (pop_ok) rptr <= rptr + 1'b1;
         count <= count + CW'(push) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/dmem_pipe.sv
// dmem_pipe: data memory with a valid/ready request channel, byte write
// strobes, LATENCY-cycle read pipeline and a QDEPTH-entry response queue.
// Optional macro DMEM_RAND_STALL_EN adds LFSR-driven request back-pressure.
module dmem_pipe
   import dmem_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int ADDR_W  = 6,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [WIDTH-1:0]         req_wdata,
   input  logic [WIDTH/8-1:0]       req_be,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_rdata,
   output logic [cnt_w(QDEPTH)-1:0] outstanding
);

   localparam int BW = WIDTH / 8;
   localparam int CW = cnt_w(QDEPTH);

   logic [WIDTH-1:0] mem [2**ADDR_W];
   logic             wr_fire;
   logic             rd_fire;
   logic             rsp_fire;
   logic             push;
   logic [WIDTH-1:0] push_data;
   logic [WIDTH-1:0] fifo_head;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;

   assign wr_fire  = req_valid && req_ready && req_we;
   assign rd_fire  = req_valid && req_ready && !req_we;
   assign rsp_fire = rsp_valid && rsp_ready;

   // Byte-masked write into the array; no reset so contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         for (int i = 0; i < BW; i++) begin
            if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

   // Read data is sampled at the acceptance edge and delayed LATENCY-1 edges
   // before entering the response queue.
   if (LATENCY == 1) begin : g_direct
      assign push      = rd_fire;
      assign push_data = mem[req_addr];
   end else begin : g_pipe
      logic [LATENCY-2:0] pv;
      logic [WIDTH-1:0]   pd [LATENCY-1];

      // Valid tags: cleared on reset so in-flight reads are discarded.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            pv <= '0;
         end else begin
            pv[0] <= rd_fire;
            for (int i = 1; i < LATENCY - 1; i++) pv[i] <= pv[i-1];
         end
      end

      // Data stages follow the valid tags; meaningful only where tagged.
      always_ff @(posedge clk) begin
         pd[0] <= mem[req_addr];
         for (int i = 1; i < LATENCY - 1; i++) pd[i] <= pd[i-1];
      end

      assign push      = pv[LATENCY-2];
      assign push_data = pd[LATENCY-2];
   end

   resp_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (rsp_fire),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign rsp_valid = !fifo_empty;
   assign rsp_rdata = rsp_valid ? fifo_head : '0;

   // Outstanding reads: counts both pipeline and queue occupancy, which is
   // what makes queue overflow impossible.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) outstanding <= '0;
      else          outstanding <= outstanding + CW'(rd_fire) - CW'(rsp_fire);
   end

`ifdef DMEM_RAND_STALL_EN
   logic [7:0] lfsr;

   // Fibonacci LFSR, taps 8,6,5,4, advancing every cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr <= LFSR_SEED;
      else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign req_ready = (outstanding < CW'(QDEPTH)) && !lfsr[0];
`else
   assign req_ready = (outstanding < CW'(QDEPTH));
`endif

   a_latency_range : assert property (@(posedge clk) (LATENCY >= 1) && (LATENCY <= 4))
      else $error("dmem_pipe: LATENCY %0d outside 1..4", LATENCY);

   a_rsp_hold : assert property (@(posedge clk) disable iff (!reset_n)
      (rsp_valid && !rsp_ready) |=> $stable(rsp_rdata))
      else $error("dmem_pipe: rsp_rdata changed while stalled");

   a_fifo_bound : assert property (@(posedge clk) disable iff (!reset_n)
      fifo_count <= CW'(QDEPTH))
      else $error("dmem_pipe: response queue over capacity");

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: table-driven directed vectors, hand sequences for the
// back-pressure / ready-boundary / reset cases, and a randomized phase. A
// word-array + response-queue reference model checks every handshake.
module tb_dmem_pipe;
   import dmem_pkg::*;

   localparam int WIDTH   = 32;
   localparam int ADDR_W  = 6;
   localparam int LATENCY = 2;
   localparam int QDEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [WIDTH-1:0]  req_wdata;
   logic [3:0]        req_be;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WIDTH-1:0]  rsp_rdata;
   logic [2:0]        outstanding;

   int checks = 0;
   int errors = 0;

   // Reference model: memory image and queue of expected read data in order.
   logic [31:0] model_mem [64];
   logic [31:0] exp_q [$];

   dmem_pipe #(
      .WIDTH   (WIDTH),
      .ADDR_W  (ADDR_W),
      .LATENCY (LATENCY),
      .QDEPTH  (QDEPTH)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_be      (req_be),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .outstanding (outstanding)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: observes both channels mid-cycle, i.e. the values that the
   // next rising edge will act on.
   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
      end else begin
         logic [31:0] mask;
         check("outstanding", 32'(outstanding), 32'(exp_q.size()));
`ifndef DMEM_RAND_STALL_EN
         check("req_ready", 32'(req_ready), 32'(exp_q.size() < QDEPTH));
`endif
         if (!rsp_valid) check("rdata_idle_zero", rsp_rdata, 32'h0);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) check("rsp_without_read", 32'(rsp_valid), 32'h0);
            else                   check("rsp_data_order", rsp_rdata, exp_q.pop_front());
         end
         if (req_valid && req_ready) begin
            if (req_we) begin
               mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
               model_mem[req_addr] = (model_mem[req_addr] & ~mask) | (req_wdata & mask);
            end else begin
               exp_q.push_back(model_mem[req_addr]);
            end
         end
      end
   end

   // Present one request and hold it until accepted; returns just after the
   // accepting edge with req_valid dropped.
   task automatic do_req(input logic we, input int addr, input logic [31:0] wd, input logic [3:0] be);
      int n = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = ADDR_W'(addr);
      req_wdata = wd;
      req_be    = be;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (!req_ready) check("req_accept_timeout", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Count mid-cycle samples until rsp_valid; ends at that negedge.
   task automatic wait_rsp(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 50);
      if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'h1);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (outstanding != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, 32'(outstanding), 32'h0);
   endtask

   typedef struct {
      dmem_req_t   req;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int n;
      int issued;
      int cyc;
      logic acc;

      tbl[0]  = '{'{1'b1, 6'd5,  32'hDEADBEEF, 4'hF}, 32'h0};
      tbl[1]  = '{'{1'b0, 6'd5,  32'h0,        4'h0}, 32'hDEADBEEF};
      tbl[2]  = '{'{1'b1, 6'd3,  32'h11223344, 4'hF}, 32'h0};
      tbl[3]  = '{'{1'b1, 6'd3,  32'hAABBCCDD, 4'h5}, 32'h0};
      tbl[4]  = '{'{1'b0, 6'd3,  32'h0,        4'hF}, 32'h11BB33DD};
      tbl[5]  = '{'{1'b1, 6'd9,  32'h00000000, 4'hF}, 32'h0};
      tbl[6]  = '{'{1'b1, 6'd9,  32'h12345678, 4'hA}, 32'h0};
      tbl[7]  = '{'{1'b0, 6'd9,  32'h0,        4'h0}, 32'h12005600};
      tbl[8]  = '{'{1'b1, 6'd9,  32'hFFFFFFFF, 4'h0}, 32'h0};
      tbl[9]  = '{'{1'b0, 6'd9,  32'h0,        4'h0}, 32'h12005600};
      tbl[10] = '{'{1'b1, 6'd63, 32'hA5A5A5A5, 4'hF}, 32'h0};
      tbl[11] = '{'{1'b0, 6'd63, 32'h0,        4'h0}, 32'hA5A5A5A5};

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 1'b1;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      check("reset_rsp_rdata", rsp_rdata, 32'h0);
      check("reset_outstanding", 32'(outstanding), 32'h0);
`ifndef DMEM_RAND_STALL_EN
      check("reset_req_ready", 32'(req_ready), 32'h1);
`endif
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vectors: writes, partial strobes, read-after-write latency.
      for (int i = 0; i < 12; i++) begin
         do_req(tbl[i].req.we, int'(tbl[i].req.addr), tbl[i].req.wdata, tbl[i].req.be);
         if (!tbl[i].req.we) begin
            wait_rsp(n);
            check($sformatf("tbl%0d_latency", i), 32'(n), 32'(LATENCY));
            check($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].exp);
            @(posedge clk);
            #1;
         end
      end

`ifndef DMEM_RAND_STALL_EN
      // Back-pressure: four stalled reads fill the window.
      for (int i = 0; i < 8; i++) do_req(1'b1, i, 32'h1000 + i, 4'hF);
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) do_req(1'b0, i, 32'h0, 4'h0);
      @(negedge clk);
      check("full_req_ready", 32'(req_ready), 32'h0);
      check("full_outstanding", 32'(outstanding), 32'h4);
      check("full_stalled_head", rsp_rdata, 32'h1000);

      // Ready boundary: response handshake and new read in the same cycle.
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 6'd4;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("boundary_ready_low", 32'(req_ready), 32'h0);
      check("boundary_rsp_valid", 32'(rsp_valid), 32'h1);
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("boundary_ready_back", 32'(req_ready), 32'h1);
      check("boundary_outstanding3", 32'(outstanding), 32'h3);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("boundary_outstanding4", 32'(outstanding), 32'h4);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      drain("backpressure_drain");
      for (int i = 5; i < 8; i++) do_req(1'b0, i, 32'h0, 4'h0);
      drain("resume_drain");
`endif

      // Reset mid-operation: in-flight reads vanish, memory survives.
      do_req(1'b1, 20, 32'h55AA55AA, 4'hF);
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) do_req(1'b0, 3, 32'h0, 4'h0);
      reset_n = 1'b0;
      #1;
      check("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
      check("midreset_outstanding", 32'(outstanding), 32'h0);
      check("midreset_rdata", rsp_rdata, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      reset_n   = 1'b1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      do_req(1'b0, 20, 32'h0, 4'h0);
      wait_rsp(n);
      check("post_reset_rdata", rsp_rdata, 32'h55AA55AA);
      @(posedge clk);
      #1;

      // Randomized phase: initialise every word, then mixed traffic with a
      // randomly stalling consumer.
      for (int a = 0; a < 64; a++) do_req(1'b1, a, $urandom, 4'hF);
      issued = 0;
      cyc    = 0;
      while (issued < 200 && cyc < 5000) begin
         if (!req_valid && $urandom_range(0, 3) != 0) begin
            req_valid = 1'b1;
            req_we    = $urandom_range(0, 1) == 1;
            req_addr  = ADDR_W'($urandom_range(0, 63));
            req_wdata = $urandom;
            req_be    = 4'($urandom_range(0, 15));
         end
         rsp_ready = $urandom_range(0, 2) != 0;
         @(negedge clk);
         acc = req_valid && req_ready;
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            issued++;
            req_valid = 1'b0;
         end
      end
      check("random_all_accepted", 32'(issued), 32'd200);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      drain("random_drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
